mem_xbar_np: RTL and testbench
==============================

// Module: mem_xbar_np
// PURPOSE
//  N-master to single-port memory front end. Arbitrates NumPorts OBI-style
//  request ports (Ibex instr/data, DMA, bench masters) onto one ram_1p
//  instance. Routes each in-order response back to its issuing port.
//  Successor to the fixed 2-port instr/data muxing used around ram_1p in
//  the core bench: adds configurable port count, round-robin fairness,
//  outstanding-request tracking and out-of-range error responses.
// PARAMETERS
//  NumPorts        2       number of request ports, 1..8
//  AddrWidth       32      byte address width, all ports
//  MemSize         'h10000 memory size in bytes, power of 2
//  MaxOutstanding  2       tag FIFO depth, >=1
// PORTS
//  clk_i         in   1             system clock
//  rst_ni        in   1             synchronous active-low reset
//  req_i         in   NumPorts      per-port request
//  gnt_o         out  NumPorts      per-port grant, combinational, onehot0
//  we_i          in   NumPorts      per-port write enable
//  be_i          in   NumPorts*4    per-port byte enables
//  addr_i        in   NumPorts*AW   per-port byte address
//  wdata_i       in   NumPorts*32   per-port write data
//  rvalid_o      out  NumPorts      per-port response valid, onehot0
//  rdata_o       out  32            response data, shared by all ports
//  err_o         out  1             response error, qualified by rvalid_o
//  mem_req_o     out  1             to ram_1p req_i
//  mem_we_o      out  1             to ram_1p we_i
//  mem_be_o      out  4             to ram_1p be_i
//  mem_addr_o    out  32            word index, (addr - base) >> 2
//  mem_wdata_o   out  32            to ram_1p wdata_i
//  mem_rvalid_i  in   1             from ram_1p rvalid_o
//  mem_rdata_i   in   32            from ram_1p rdata_o
// BEHAVIOUR
//  - Reset (rst_ni low at clk_i edge): RR pointer=0, tag FIFO empty,
//    count=0. All outputs 0 during reset; gnt_o forced 0.
//  - Memory contract: in-order, exactly 1 cycle req->rvalid (ram_1p).
//  - Arbitration: winner = first requesting port at or after RR pointer,
//    wrapping NumPorts-1 -> 0. One grant per cycle.
//  - Grant allowed when count<MaxOutstanding, or count==MaxOutstanding
//    and a pop happens this cycle. Otherwise gnt_o=0, requests held.
//  - On grant: RR pointer <= winner+1 (mod NumPorts); push {port_id, err}.
//    mem_req_o=1 and mem_* driven from the winner, except err entries.
//  - Response: rvalid_o[head.port_id]=1 when (head real and mem_rvalid_i)
//    or (head err, FIFO non-empty). Pop on either case.
//    rdata_o=mem_rdata_i for real, 0 for err.
//  - Err head responds in the first cycle it is head; ordering is kept
//    by the FIFO. mem_rvalid_i while head is err, or while FIFO empty,
//    is a protocol violation; SVA assertion fires, no pop.
//  - Simultaneous push+pop: count unchanged; at count==MaxOutstanding
//    the push is accepted.
//  - Reset mid-transfer flushes FIFO. Responses from memory in the next
//    cycle are dropped without assertion for one cycle after reset.
//  - Writes produce rvalid (Ibex requires it); rdata_o is don't-care.
// CONFIGURATION
//  MEM_XBAR_ADDR_CHECK_EN defined: addr outside [0,MemSize) is granted
//    and pushed as err entry, no mem_req_o, err_o=1 on its response.
//  MEM_XBAR_ADDR_CHECK_EN undefined: no range check; mem_addr_o =
//    addr[$clog2(MemSize)-1:2] (wraps modulo MemSize); err_o tied 0.
// TESTING
//  1 reset 3 cycles, all req=1 -> all outputs 0; gnt_o[0] in the first
//    cycle after rst_ni=1.
//  2 NumPorts=3, req=3'b111 held 6 cycles -> gnt order 0,1,2,0,1,2;
//    each rvalid 1 cycle after its grant, at the matching port.
//  3 port1 writes 0xDEADBEEF @0x100 be=4'hF, port0 reads 0x100 next cycle
//    -> port0 rvalid, rdata_o=0xDEADBEEF.
//  4 MaxOutstanding=1, mem_rvalid_i stuck 0 (fault model) -> one grant,
//    then gnt_o=0 until a response pops the FIFO.
//  5 ADDR_CHECK_EN, MemSize='h10000: read @0x10000 by port1 -> no
//    mem_req_o, rvalid_o[1] next cycle, err_o=1, rdata_o=0; without
//    macro -> mem_addr_o=0, err_o=0.
//  6 rst_ni low the cycle after a grant -> FIFO flushed, no rvalid_o,
//    no assertion failure, RR pointer=0.

Source files
------------

// File: rtl/mem_xbar_np.sv
// -----------------------------------------------------------------------------
// mem_xbar_np
//
// Purpose:
//   Front end that lets NumPorts OBI-style masters share one single-port RAM
//   (ram_1p). A round-robin arbiter issues at most one grant per cycle. A small
//   tag FIFO remembers, in issue order, which port each outstanding request
//   came from, so the in-order RAM responses are routed back to that port.
//   The RAM always answers exactly one cycle after a request.
//
// Optional feature (macro MEM_XBAR_ADDR_CHECK_EN):
//   defined   - a granted address outside [0, MemSize) never reaches the RAM.
//               It is queued as an error entry and answered with err_o=1,
//               rdata_o=0 in the first cycle that entry is at the FIFO head.
//   undefined - no range check. The address wraps modulo MemSize and err_o
//               is tied to 0.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i/gnt_o            per-port request / combinational onehot0 grant
//   we_i, be_i             per-port write enable, byte enables (4 per port)
//   addr_i, wdata_i        per-port byte address (AddrWidth), write data (32)
//   rvalid_o               per-port onehot0 response valid
//   rdata_o, err_o         shared response data and error flag,
//                          both qualified by rvalid_o
//   mem_req_o .. mem_wdata_o  request to ram_1p; mem_addr_o is a word index
//   mem_rvalid_i, mem_rdata_i response from ram_1p
//   All outputs are 0 while rst_ni is low.
// -----------------------------------------------------------------------------
module mem_xbar_np #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MemSize        = 'h10000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts-1:0]           req_i,
    output logic [NumPorts-1:0]           gnt_o,
    input  logic [NumPorts-1:0]           we_i,
    input  logic [NumPorts*4-1:0]         be_i,
    input  logic [NumPorts*AddrWidth-1:0] addr_i,
    input  logic [NumPorts*32-1:0]        wdata_i,
    output logic [NumPorts-1:0]           rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          err_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [3:0]                    mem_be_o,
    output logic [31:0]                   mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i
);

    localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned MemAw = $clog2(MemSize);

    // One FIFO entry per outstanding request: who issued it, and whether it
    // is an error entry that is answered locally instead of by the RAM.
    typedef struct packed {
        logic [PortW-1:0] port_id;
        logic             err;
    } tag_t;

    // -------------------------------------------------------------------------
    // Per-port views of the flattened request buses
    // -------------------------------------------------------------------------
    logic [AddrWidth-1:0] addr_arr  [NumPorts];
    logic [31:0]          wdata_arr [NumPorts];
    logic [3:0]           be_arr    [NumPorts];

    always_comb begin
        for (int j = 0; j < NumPorts; j++) begin
            addr_arr[j]  = addr_i[j*AddrWidth +: AddrWidth];
            wdata_arr[j] = wdata_i[j*32 +: 32];
            be_arr[j]    = be_i[j*4 +: 4];
        end
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PortW-1:0] rr_q, rr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             drop_q;   // first cycle after reset: stray RAM response allowed
    tag_t             fifo_q [MaxOutstanding];

    // -------------------------------------------------------------------------
    // Round-robin arbiter: the lowest requesting port at or above rr_q wins;
    // if there is none, the lowest requesting port below rr_q wins.
    // -------------------------------------------------------------------------
    logic             any_req;
    logic [PortW-1:0] winner;

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int j = 0; j < NumPorts; j++) begin
            if (!any_req && req_i[j] && (PortW'(j) >= rr_q)) begin
                any_req = 1'b1;
                winner  = PortW'(j);
            end
        end
        for (int j = 0; j < NumPorts; j++) begin
            if (!any_req && req_i[j]) begin
                any_req = 1'b1;
                winner  = PortW'(j);
            end
        end
    end

    logic [AddrWidth-1:0] win_addr;
    logic                 win_err;

    assign win_addr = addr_arr[winner];

`ifdef MEM_XBAR_ADDR_CHECK_EN
    assign win_err = (win_addr >> MemAw) != '0;
`else
    assign win_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Tag FIFO control
    // -------------------------------------------------------------------------
    tag_t head;
    tag_t push_tag;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic grant;

    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(MaxOutstanding));

    // An error head is answered without waiting for the RAM; a real head
    // waits for mem_rvalid_i.
    assign pop = !fifo_empty && (head.err || mem_rvalid_i);

    // A full FIFO still accepts a new request when the head retires this cycle.
    assign grant = rst_ni && any_req && (!fifo_full || pop);

    assign push_tag = '{port_id: winner, err: win_err};

    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (grant) begin
            rr_d     = (winner == PortW'(NumPorts - 1)) ? '0 : winner + 1'b1;
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b1;
        end else begin
            rr_q     <= rr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= 1'b0;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only read after it has
    // been written, and count_q/pointers are what reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            fifo_q[wr_ptr_q] <= push_tag;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int j = 0; j < NumPorts; j++) begin
            gnt_o[j]    = grant && (winner == PortW'(j));
            rvalid_o[j] = rst_ni && pop && (head.port_id == PortW'(j));
        end

        // Error entries are granted but never reach the RAM.
        mem_req_o   = grant && !win_err;
        mem_we_o    = mem_req_o && we_i[winner];
        mem_be_o    = mem_req_o ? be_arr[winner] : 4'h0;
        mem_addr_o  = mem_req_o ? 32'(win_addr[MemAw-1:2]) : 32'h0;
        mem_wdata_o = mem_req_o ? wdata_arr[winner] : 32'h0;

        rdata_o = (rst_ni && pop && !head.err) ? mem_rdata_i : 32'h0;
    end

`ifdef MEM_XBAR_ADDR_CHECK_EN
    assign err_o = rst_ni && pop && head.err;
`else
    assign err_o = 1'b0;
`endif

    // A RAM response is only legal when a real request is waiting for it.
    // The first cycle after reset is exempt: a request issued just before
    // reset may still answer then.
    mem_rsp_expected_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (drop_q || (!fifo_empty && !head.err))
    );

endmodule

// File: tb/tb_mem_xbar_np.sv
// -----------------------------------------------------------------------------
// tb_mem_xbar_np
//
// Self-checking bench for mem_xbar_np with three ports and two outstanding
// requests. A behavioural single-port RAM drives the memory side. It can be
// stalled so that the outstanding limit is reached. A reference model keeps
// the expected responses in a queue and the expected memory contents in an
// associative array. Every clock cycle the model predicts the grant, the
// response and the RAM request, and the bench compares them with the DUT.
// -----------------------------------------------------------------------------
module tb_mem_xbar_np;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int MS = 'h10000;
    localparam int MO = 2;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     req;
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     we;
    logic [NP*4-1:0]   be;
    logic [NP*AW-1:0]  addr;
    logic [NP*32-1:0]  wdata;
    logic [NP-1:0]     rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    mem_xbar_np #(
        .NumPorts      (NP),
        .AddrWidth     (AW),
        .MemSize       (MS),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------------- RAM model
    logic [31:0] ram [int unsigned];
    logic [31:0] ram_pend [$];
    bit          stall;
    logic        nxt_rvalid;
    logic [31:0] nxt_rdata;

    // ---------------------------------------------------------- reference model
    typedef struct {
        int          port;
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] ref_mem [int unsigned];
    int          m_rr;
    int          m_win;
    bit          m_pop;
    bit          m_grant;
    bit          m_oor;

    // Values seen at the last sample point, for the directed checks.
    logic [NP-1:0] smp_gnt;
    logic [NP-1:0] smp_rvalid;
    logic [31:0]   smp_rdata;
    logic          smp_err;
    logic          smp_mem_req;
    logic [31:0]   smp_mem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic logic [31:0] ram_rd(input int unsigned w);
        return ram.exists(w) ? ram[w] : 32'h0;
    endfunction

    function automatic bit addr_oor(input logic [31:0] a);
`ifdef MEM_XBAR_ADDR_CHECK_EN
        return a >= 32'(MS);
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_port(input int p, input bit r, input bit w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
        req[p]             = r;
        we[p]              = w;
        be[p*4 +: 4]       = b;
        addr[p*AW +: AW]   = a;
        wdata[p*32 +: 32]  = d;
    endtask

    // Predicts this cycle's outputs from the model state and compares them.
    task automatic model_check();
        logic [31:0] a;
        int          p;
        if (!rst_n) begin
            m_pop   = 1'b0;
            m_grant = 1'b0;
            check("rst_gnt",       32'(gnt),       32'h0);
            check("rst_rvalid",    32'(rvalid),    32'h0);
            check("rst_rdata",     rdata,          32'h0);
            check("rst_err",       32'(err),       32'h0);
            check("rst_mem_req",   32'(mem_req),   32'h0);
            check("rst_mem_we",    32'(mem_we),    32'h0);
            check("rst_mem_be",    32'(mem_be),    32'h0);
            check("rst_mem_addr",  mem_addr,       32'h0);
            check("rst_mem_wdata", mem_wdata,      32'h0);
        end else begin
            m_pop = (exp_q.size() > 0) && (exp_q[0].err || mem_rvalid);
            m_win = -1;
            for (int off = 0; off < NP; off++) begin
                p = (m_rr + off) % NP;
                if (m_win < 0 && req[p]) m_win = p;
            end
            m_grant = (m_win >= 0) && ((exp_q.size() < MO) || m_pop);
            check("gnt",    32'(gnt),    m_grant ? (32'd1 << m_win) : 32'd0);
            check("rvalid", 32'(rvalid), m_pop ? (32'd1 << exp_q[0].port) : 32'd0);
            if (m_pop) begin
                check("err", 32'(err), 32'(exp_q[0].err));
                if (exp_q[0].err)     check("rdata_err", rdata, 32'h0);
                else if (exp_q[0].rd) check("rdata",     rdata, exp_q[0].data);
            end
            m_oor = 1'b0;
            if (m_grant) begin
                a     = addr[m_win*AW +: AW];
                m_oor = addr_oor(a);
                check("mem_req", 32'(mem_req), 32'(!m_oor));
                if (!m_oor) begin
                    check("mem_we",    32'(mem_we),  32'(we[m_win]));
                    check("mem_be",    32'(mem_be),  32'(be[m_win*4 +: 4]));
                    check("mem_addr",  mem_addr,     (a % MS) >> 2);
                    check("mem_wdata", mem_wdata,    wdata[m_win*32 +: 32]);
                end
            end else begin
                check("mem_req_idle", 32'(mem_req), 32'h0);
            end
        end
    endtask

    // Advances the model by one clock cycle.
    task automatic model_update();
        logic [31:0]  a;
        int unsigned  w;
        exp_t         e;
        if (!rst_n) begin
            exp_q.delete();
            m_rr = 0;
        end else begin
            if (m_pop) exp_q.delete(0);
            if (m_grant) begin
                a      = addr[m_win*AW +: AW];
                w      = (a % MS) >> 2;
                e.port = m_win;
                e.err  = m_oor;
                e.rd   = !we[m_win];
                e.data = ref_rd(w);
                if (we[m_win] && !m_oor) begin
                    ref_mem[w] = merge(ref_rd(w), wdata[m_win*32 +: 32], be[m_win*4 +: 4]);
                end
                exp_q.push_back(e);
                m_rr = (m_win + 1) % NP;
            end
        end
    endtask

    // The RAM sees this cycle's request and computes next cycle's response.
    task automatic ram_eval();
        logic [31:0] w;
        if (!rst_n) begin
            ram_pend.delete();
            nxt_rvalid = 1'b0;
            nxt_rdata  = 32'h0;
        end else begin
            if (mem_req) begin
                w = ram_rd(mem_addr);
                if (mem_we) begin
                    ram[mem_addr] = merge(w, mem_wdata, mem_be);
                    ram_pend.push_back($urandom());
                end else begin
                    ram_pend.push_back(w);
                end
            end
            if (!stall && ram_pend.size() > 0) begin
                nxt_rvalid = 1'b1;
                nxt_rdata  = ram_pend.pop_front();
            end else begin
                nxt_rvalid = 1'b0;
                nxt_rdata  = $urandom();
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        smp_gnt      = gnt;
        smp_rvalid   = rvalid;
        smp_rdata    = rdata;
        smp_err      = err;
        smp_mem_req  = mem_req;
        smp_mem_addr = mem_addr;
        ram_eval();
        model_update();
        @(posedge clk);
        #1;
        mem_rvalid = nxt_rvalid;
        mem_rdata  = nxt_rdata;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        we         = '0;
        be         = '0;
        addr       = '0;
        wdata      = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        stall      = 1'b0;
        m_rr       = 0;

        // Reset for 3 cycles with every port requesting: all outputs stay 0.
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 4'hF, 32'(p * 4), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_gnt", 32'(smp_gnt), 32'h0);
        end

        // Same requests held for 6 cycles: grants rotate 0,1,2,0,1,2 and each
        // response arrives one cycle later at the port that was granted.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_order", 32'(smp_gnt), 32'd1 << (i % NP));
            if (i > 0) check("rr_rvalid", 32'(smp_rvalid), 32'd1 << ((i - 1) % NP));
        end
        req = '0;
        step();
        check("rr_last_rvalid", 32'(smp_rvalid), 32'd1 << 2);

        // Port 1 writes 0xDEADBEEF to 0x100; port 0 reads it back next cycle.
        set_port(1, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
        step();
        check("wr_gnt", 32'(smp_gnt), 32'h2);
        req = '0;
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        step();
        check("rd_gnt", 32'(smp_gnt), 32'h1);
        req = '0;
        step();
        check("rd_rvalid", 32'(smp_rvalid), 32'h1);
        check("rd_data",   smp_rdata,       32'hDEADBEEF);

        // RAM stalled: two grants fill the FIFO, then no grant until a
        // response retires the head; a grant is then issued while still full.
        stall = 1'b1;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, 4'hF, 32'(p * 8), 32'h0);
        step();
        check("stall_gnt0", 32'(smp_gnt), 32'h2);
        step();
        check("stall_gnt1", 32'(smp_gnt), 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_blocked", 32'(smp_gnt), 32'h0);
        end
        stall = 1'b0;
        step();
        check("stall_release", 32'(smp_gnt), 32'h0);
        step();
        check("full_pop_gnt",    32'(smp_gnt),    32'h1);
        check("full_pop_rvalid", 32'(smp_rvalid), 32'h2);
        idle(4);

        // Read at MemSize from port 1.
        req = '0;
        set_port(1, 1'b1, 1'b0, 4'hF, 32'(MS), 32'h0);
        step();
        check("oor_gnt", 32'(smp_gnt), 32'h2);
`ifdef MEM_XBAR_ADDR_CHECK_EN
        check("oor_no_mem_req", 32'(smp_mem_req), 32'h0);
        req = '0;
        step();
        check("oor_rvalid", 32'(smp_rvalid), 32'h2);
        check("oor_err",    32'(smp_err),    32'h1);
        check("oor_rdata",  smp_rdata,       32'h0);
`else
        check("wrap_mem_req",  32'(smp_mem_req), 32'h1);
        check("wrap_mem_addr", smp_mem_addr,     32'h0);
        req = '0;
        step();
        check("wrap_rvalid", 32'(smp_rvalid), 32'h2);
        check("wrap_err",    32'(smp_err),    32'h0);
`endif
        idle(2);

        // Reset the cycle after a grant: the response is dropped, the FIFO is
        // flushed and the round-robin pointer restarts at port 0.
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        step();
        check("mid_gnt", 32'(smp_gnt), 32'h1);
        rst_n = 1'b0;
        req   = '1;
        step();
        check("mid_rst_rvalid", 32'(smp_rvalid), 32'h0);
        rst_n = 1'b1;
        req   = '0;
        step();
        check("post_rst_rvalid", 32'(smp_rvalid), 32'h0);
        req = '1;
        step();
        check("post_rst_rr", 32'(smp_gnt), 32'h1);
        idle(3);

        // Random traffic, RAM never stalled, addresses may be out of range.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         4'($urandom_range(1, 15)),
                         32'($urandom_range(0, 31) * 4) + (($urandom_range(0, 7) == 0) ? 32'(MS) : 32'h0),
                         $urandom());
            end
            step();
        end
        idle(4);

        // Random traffic with random RAM stalls, addresses in range.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < NP; p++) begin
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         4'($urandom_range(1, 15)), 32'($urandom_range(0, 31) * 4), $urandom());
            end
            step();
        end
        stall = 1'b0;
        idle(6);
        check("drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
